// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// clock_set_ctrl : HH:MM time-keeping and two-button time-setting controller
// Option macro   : AUTO_REPEAT_EN (held btn_inc auto-repeats in set modes)
// Revision       : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
  parameter int DEB_CYCLES  = 500000,
  parameter int BLINK_TICKS = 5,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [15:0] time_bcd,
  output logic [3:0]  les,
  output logic [3:0]  points,
  output logic [1:0]  mode,
  output logic        day_wrap
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int BW = (BLINK_TICKS < 2) ? 1 : $clog2(BLINK_TICKS);
  localparam logic [DW-1:0] C_DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_SET_H = 2'b01,
    S_SET_M = 2'b10
  } state_t;

  logic [1:0] w_btn_raw;
  logic [1:0] w_deb;
  logic [1:0] w_press;
  logic       w_mode_press;
  logic       w_inc_press;
  logic       w_inc_ev;

  state_t r_state;
  state_t w_state_nxt;

  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_nxt;
  logic          r_phase;
  logic          w_phase_nxt;
  logic [3:0]    r_les;
  logic [3:0]    w_les_nxt;

  logic [7:0] r_hour;
  logic [7:0] r_min;
  logic [7:0] w_hour_nxt;
  logic [7:0] w_min_nxt;
  logic [8:0] w_min_inc;
  logic [8:0] w_hour_inc;
  logic       w_wrap;
  logic       r_day_wrap;

  assign w_btn_raw = {btn_inc, btn_mode};

  // Index 0 = mode button, index 1 = increment button.
  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_d;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        r_sync    <= 2'b00;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_sync    <= {r_sync[0], w_btn_raw[gi]};
        r_level_d <= r_level;
        if (r_sync[1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == C_DEB_LAST) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
    end

    assign w_deb[gi]   = r_level;
    assign w_press[gi] = r_level & ~r_level_d;
  end

  assign w_mode_press = w_press[0];
  assign w_inc_press  = w_press[1];

`ifdef AUTO_REPEAT_EN
  localparam int RDW = (REPEAT_DLY < 1) ? 1 : $clog2(REPEAT_DLY + 1);
  localparam int RRW = (REPEAT_RATE < 2) ? 1 : $clog2(REPEAT_RATE);
  localparam logic [RDW-1:0] C_REP_DLY  = RDW'(REPEAT_DLY);
  localparam logic [RRW-1:0] C_REP_LAST = RRW'(REPEAT_RATE - 1);

  logic [RDW-1:0] r_rep_dly;
  logic [RRW-1:0] r_rep_rate;
  logic           w_held;
  logic           w_rep_fire;
  logic           w_unused_deb;

  assign w_unused_deb = w_deb[0];
  assign w_held       = w_deb[1] & (r_state != S_RUN);
  assign w_rep_fire   = tick & w_held & (r_rep_dly == C_REP_DLY) & (r_rep_rate == C_REP_LAST);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_rep_dly  <= '0;
      r_rep_rate <= '0;
    end else if (!w_held || w_mode_press) begin
      r_rep_dly  <= '0;
      r_rep_rate <= '0;
    end else if (tick) begin
      if (r_rep_dly != C_REP_DLY) begin
        r_rep_dly <= r_rep_dly + RDW'(1);
      end else if (r_rep_rate == C_REP_LAST) begin
        r_rep_rate <= '0;
      end else begin
        r_rep_rate <= r_rep_rate + RRW'(1);
      end
    end
  end

  assign w_inc_ev = w_inc_press | w_rep_fire;
`else
  logic w_unused_rep;
  assign w_unused_rep = ^{REPEAT_DLY, REPEAT_RATE, w_deb};
  assign w_inc_ev     = w_inc_press;
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_press) begin
      case (r_state)
        S_RUN:   w_state_nxt = S_SET_H;
        S_SET_H: w_state_nxt = S_SET_M;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // Any mode change restarts the blink cycle so the new digits show immediately.
  always_comb begin
    w_blink_nxt = r_blink_cnt;
    w_phase_nxt = r_phase;
    if (w_mode_press) begin
      w_blink_nxt = '0;
      w_phase_nxt = 1'b0;
    end else if (tick) begin
      if (r_blink_cnt == C_BLINK_LAST) begin
        w_blink_nxt = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_blink_nxt = r_blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    w_les_nxt = 4'b0000;
    if (w_phase_nxt) begin
      if (w_state_nxt == S_SET_H) begin
        w_les_nxt = 4'b1100;
      end else if (w_state_nxt == S_SET_M) begin
        w_les_nxt = 4'b0011;
      end
    end
  end

  function automatic logic [8:0] f_inc_min(input logic [3:0] m1, input logic [3:0] m0);
    if (m0 != 4'd9) begin
      return {1'b0, m1, m0 + 4'd1};
    end else if (m1 != 4'd5) begin
      return {1'b0, m1 + 4'd1, 4'd0};
    end
    return 9'h100;
  endfunction

  function automatic logic [8:0] f_inc_hour(input logic [3:0] h1, input logic [3:0] h0);
    if ((h1 == 4'd2) && (h0 == 4'd3)) begin
      return 9'h100;
    end else if (h0 == 4'd9) begin
      return {1'b0, h1 + 4'd1, 4'd0};
    end
    return {1'b0, h1, h0 + 4'd1};
  endfunction

  always_comb begin
    w_min_inc  = f_inc_min(r_min[7:4], r_min[3:0]);
    w_hour_inc = f_inc_hour(r_hour[7:4], r_hour[3:0]);
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour;
    w_wrap     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (tick) begin
          w_min_nxt = w_min_inc[7:0];
          if (w_min_inc[8]) begin
            w_hour_nxt = w_hour_inc[7:0];
            w_wrap     = w_hour_inc[8];
          end
        end
      end
      S_SET_H: begin
        if (w_inc_ev && !w_mode_press) begin
          w_hour_nxt = w_hour_inc[7:0];
        end
      end
      S_SET_M: begin
        if (w_inc_ev && !w_mode_press) begin
          w_min_nxt = w_min_inc[7:0];
        end
      end
      default: begin
        w_min_nxt = r_min;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_hour      <= 8'h00;
      r_min       <= 8'h00;
      r_day_wrap  <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_les       <= 4'b0000;
    end else begin
      r_hour      <= w_hour_nxt;
      r_min       <= w_min_nxt;
      r_day_wrap  <= w_wrap;
      r_blink_cnt <= w_blink_nxt;
      r_phase     <= w_phase_nxt;
      r_les       <= w_les_nxt;
    end
  end

  assign time_bcd = {r_hour, r_min};
  assign les      = r_les;
  assign points   = 4'b0100;
  assign mode     = r_state;
  assign day_wrap = r_day_wrap;

endmodule
`default_nettype wire
